// File: rtl/data_memory.sv
// data_memory: fixed-latency 256-bit cache-line memory sitting behind the data cache.
// Optional macro DATA_MEMORY_RANGE_CHECK_EN adds err_o and flags addresses >= DEPTH*32.
module data_memory #(
  parameter int DEPTH     = 512,
  parameter int LATENCY   = 10,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          addr_i,
  input  logic [LINE_BITS-1:0] data_i,
  input  logic                 enable_i,
  input  logic                 write_i,
  output logic                 ack_o,
`ifdef DATA_MEMORY_RANGE_CHECK_EN
  output logic                 err_o,
`endif
  output logic [LINE_BITS-1:0] data_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 wr_q, wr_d;
  logic                 flag_q, flag_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d;
  logic                 ack_q, ack_d;
  logic                 mem_we_s;
  logic                 unused_addr_s;

  logic [LINE_BITS-1:0] mem [DEPTH];

`ifdef DATA_MEMORY_RANGE_CHECK_EN
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 5;
  logic err_q, err_d;
  logic range_bad_s;

  assign range_bad_s = ({1'b0, addr_i} >= ADDR_LIMIT);
  assign err_o       = err_q;
`endif

  // Low offset bits (and high bits beyond the index) intentionally do not matter.
  assign unused_addr_s = ^addr_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    flag_d   = flag_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;
    mem_we_s = 1'b0;
`ifdef DATA_MEMORY_RANGE_CHECK_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          idx_d   = addr_i[5 +: IDX_W];
          wr_d    = write_i;
          wdata_d = data_i;
          cnt_d   = CNT_LOAD;
`ifdef DATA_MEMORY_RANGE_CHECK_EN
          flag_d  = range_bad_s;
`else
          flag_d  = 1'b0;
`endif
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 8'd0) begin
          if (wr_q) begin
            mem_we_s = ~flag_q;
          end else if (flag_q) begin
            rdata_d = {LINE_BITS{1'b0}};
          end else begin
            rdata_d = mem[idx_q];
          end
          ack_d   = 1'b1;
`ifdef DATA_MEMORY_RANGE_CHECK_EN
          err_d   = flag_q;
`endif
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= {IDX_W{1'b0}};
      wr_q    <= 1'b0;
      flag_q  <= 1'b0;
      wdata_q <= {LINE_BITS{1'b0}};
      rdata_q <= {LINE_BITS{1'b0}};
      ack_q   <= 1'b0;
`ifdef DATA_MEMORY_RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      flag_q  <= flag_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
`ifdef DATA_MEMORY_RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Array is never cleared; reset only blocks a pending commit.
  always_ff @(posedge clk_i) begin
    if (rst_i && mem_we_s) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign ack_o  = ack_q;
  assign data_o = rdata_q;

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Off-chip data memory model directly downstream of the CPU's data cache. It serves 256-bit (32-byte) cache-line reads and write-backs.
- The cache drives the enable/write/address/data request bundle. The block answers after a fixed, parameterised latency with a one-cycle ack.
- Used in the top-level testbench to exercise cache stalls (mem_stall).

Parameters:
- DEPTH, 512: number of 256-bit lines stored.
- LATENCY, 10: clock edges from request acceptance to the ack_o pulse. Legal range 2..255.
- LINE_BITS, 256: line width. Fixed by the cache interface; do not override.

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  reset, synchronous, active-low.
- addr_i  in  32  byte address. Bits [4:0] are ignored. Line index = addr_i[5 +: log2(DEPTH)].
- data_i  in  256  write-back line data.
- enable_i  in  1  request valid. Held high by the cache until ack_o.
- write_i  in  1  1 = write line, 0 = read line. Sampled with enable_i.
- ack_o  out  1  one-cycle completion pulse.
- data_o  out  256  read line data.

Behaviour:
- Reset (rst_i low at a rising edge) sets:
  - state = IDLE, counter = 0, ack_o = 0, data_o = 0.
  - Any pending request is discarded; a pending write is never committed.
  - Memory array contents are not reset.
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - If enable_i = 1 at an edge, capture addr_i line index, write_i and data_i into request registers.
  - Load counter = LATENCY-2 and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Decrement the counter each edge. The inputs enable_i, write_i, addr_i and data_i are ignored; only the captured copies are used.
  - When counter = 0, at that edge:
    - write: mem[idx] <= captured data.
    - read: data_o <= mem[idx].
    - Set ack_o <= 1 and go to ACK.
- ACK:
  - ack_o is high for exactly this cycle.
  - At the next edge, ack_o <= 0 and go to IDLE. enable_i is not sampled in ACK.
  - A new request is accepted in IDLE, at the earliest 2 edges after ack_o rises. This covers back-to-back write-back then refill.
- Latency: acceptance at edge E0 means ack_o is high during the cycle following edge E0+LATENCY-1 (ack_o rises LATENCY-1 edges after E0).
- data_o:
  - Updates only on read completion.
  - Holds its value through writes and idle time.
  - Is valid in the ACK cycle and afterwards.
- Write data is visible to a later read. Read-after-write to the same line returns the new data.
- Addressing: the index is truncated, so addresses at or above DEPTH*32 wrap modulo DEPTH. Low 5 bits never affect behaviour.
- enable_i dropped while in BUSY does not cancel the request; ack_o still pulses.
- Reset asserted in BUSY or ACK: return to IDLE, ack_o = 0 next cycle, no memory update.

Optional Feature:
- Macro: DATA_MEMORY_RANGE_CHECK_EN.
- Defined:
  - Adds output err_o (1 bit, reset 0).
  - At acceptance, if addr_i >= DEPTH*32, the request is flagged. Flagged writes are suppressed; flagged reads return data_o = 0.
  - err_o pulses together with ack_o. Latency is unchanged.
- Undefined: no err_o port; out-of-range addresses wrap as described.

Test Plan:
- Reset then idle: rst_i low for 2 edges, enable_i = 0 for 20 cycles -> ack_o = 0 and data_o = 0 throughout.
- Write/read: write addr 0x0000_0040 with data {8{32'hDEADBEEF}}, then read 0x0000_0040 -> each ack_o rises exactly LATENCY-1 = 9 edges after acceptance and is 1 cycle wide; read data_o = {8{32'hDEADBEEF}}.
- Offset ignore and wrap (DEPTH = 512): write 0x0000_0020 with all-ones, then read 0x0000_403F -> same line (index 1 after wrap), data_o = all-ones.
- Back-to-back: write 0x80 with 256'h1 held until ack, then immediately enable a read of 0x80 -> second acceptance 2 edges after the first ack rises; data_o = 256'h1; exactly two ack pulses.
- Input churn during BUSY: change addr_i and data_i and drop enable_i mid-request -> the captured address and data are used and ack_o still pulses.
- Reset mid-write: rst_i low 5 cycles after write acceptance to 0x100 -> no ack_o; a subsequent read of 0x100 returns the prior contents.
- With DATA_MEMORY_RANGE_CHECK_EN: read 0x0000_4000 -> err_o = 1 and ack_o = 1 in the same cycle, data_o = 0.
